uart_tx_scheduler: RTL and testbench

//  Memory-mapped transmit controller that sits between the MCU data-bus decoder and uart_tx.
//  It buffers CPU byte writes in a FIFO and starts the UART one byte at a time.

---
 rtl/uart_tx_scheduler_pkg.sv | 38 +++
 rtl/uart_tx_scheduler_sync_fifo.sv | 61 ++++++
 rtl/uart_tx_scheduler.sv | 110 +++++++++++
 tb/tb_uart_tx_scheduler.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: register offsets,
// STATUS bit positions, FSM encodings and the STATUS word packer.
package uart_tx_scheduler_pkg;

    localparam logic UART_TXDATA_OFS = 1'b0;
    localparam logic UART_STATUS_OFS = 1'b1;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 8;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LAUNCH    = 2'd1;
    localparam logic [1:0] S_WAIT_ACK  = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    typedef struct packed {
        logic       busy;
        logic       full;
        logic       empty;
        logic       overflow;
        logic [7:0] count;
    } status_t;

    function automatic logic [31:0] pack_status(input status_t s);
        logic [31:0] w;
        w                     = '0;
        w[ST_BUSY]            = s.busy;
        w[ST_FULL]            = s.full;
        w[ST_EMPTY]           = s.empty;
        w[ST_OVF]             = s.overflow;
        w[ST_CNT_LSB +: 8]    = s.count;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_sync_fifo.sv
// Generic synchronous FIFO with occupancy count; full/empty derive from the
// count alone so the pointers can wrap freely. Shared with the future RX path.
module sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i & ~full_o;
    assign do_pop     = pop_i & ~empty_o;
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            // A simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Memory-mapped UART transmit scheduler: queues CPU byte stores and hands
// them to uart_tx one at a time, only while the transmitter is idle.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int  DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        write_enable,
    input  logic        read_enable,
    input  logic        addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        irq_tx_empty
);

    logic [1:0]       state_q, state_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic             push_req;
    logic             ovf_clr;
    logic             launch;
    status_t          status;
    logic             unused_wdata;

    assign push_req     = cs & write_enable & (addr == UART_TXDATA_OFS);
    assign ovf_clr      = cs & write_enable & (addr == UART_STATUS_OFS) & write_data[ST_OVF];
    assign launch       = (state_q == S_IDLE) & ~fifo_empty & ~tx_busy;
    assign unused_wdata = ^write_data[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_req),
        .push_data_i (write_data[7:0]),
        .pop_i       (launch),
        .pop_data_o  (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // WAIT_ACK tolerates a transmitter that raises busy one cycle after the start pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (launch)   state_d = S_LAUNCH;
            S_LAUNCH:                  state_d = S_WAIT_ACK;
            S_WAIT_ACK:  if (tx_busy)  state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (!tx_busy) state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_data_d  = launch ? fifo_head : tx_data_q;
        overflow_d = overflow_q;
        if (push_req && fifo_full) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tx_data_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        status          = '0;
        status.busy     = (state_q != S_IDLE) | tx_busy;
        status.full     = fifo_full;
        status.empty    = fifo_empty;
        status.overflow = overflow_q;
        status.count    = 8'(fifo_count);
    end

    always_comb begin
        read_data = '0;
        if (cs && read_enable && (addr == UART_STATUS_OFS)) begin
            read_data = pack_status(status);
        end
    end

    assign tx_start     = (state_q == S_LAUNCH);
    assign tx_data      = tx_data_q;
    assign irq_tx_empty = fifo_empty & (state_q == S_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler with a simple busy-counting uart_tx model.
module tb_uart_tx_scheduler;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0;
    logic        write_enable = 1'b0;
    logic        read_enable = 1'b0;
    logic        addr = 1'b0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        irq_tx_empty;

    int          cycleCnt = 0;
    int          busyLen = 4;
    int          busyCnt = 0;
    logic        holdBusy = 1'b0;
    int          lastPushCycle = 0;
    int          checkCnt = 0;
    int          passCnt = 0;

    logic [7:0]  expQ[$];
    logic [7:0]  obsData[$];
    int          obsCycle[$];

    uart_tx_scheduler #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cs           (cs),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .addr         (addr),
        .write_data   (write_data),
        .read_data    (read_data),
        .tx_busy      (tx_busy),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .irq_tx_empty (irq_tx_empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // uart_tx stand-in: busy for busyLen cycles after each start pulse
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busyCnt = 0;
        end else if (tx_start) begin
            busyCnt = busyLen;
        end else if (busyCnt > 0) begin
            busyCnt = busyCnt - 1;
        end
    end

    assign tx_busy = (busyCnt != 0) | holdBusy;

    always @(negedge clk) begin
        if (rst_n && tx_start) begin
            obsData.push_back(tx_data);
            obsCycle.push_back(cycleCnt);
        end
    end

    task automatic applyStimulus(input logic a, input logic [31:0] d);
        @(negedge clk);
        lastPushCycle = cycleCnt;
        cs = 1'b1;
        write_enable = 1'b1;
        addr = a;
        write_data = d;
        @(posedge clk);
        #1;
        cs = 1'b0;
        write_enable = 1'b0;
        addr = 1'b0;
        write_data = '0;
    endtask

    task automatic pushByte(input logic [7:0] b);
        expQ.push_back(b);
        applyStimulus(1'b0, {24'h0, b});
    endtask

    task automatic cpuRead(output logic [31:0] d);
        @(negedge clk);
        cs = 1'b1;
        read_enable = 1'b1;
        addr = 1'b1;
        #1;
        d = read_data;
        cs = 1'b0;
        read_enable = 1'b0;
        addr = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitObs(input int n, input int budget);
        int k = 0;
        while (obsData.size() < n && k < budget) begin
            @(negedge clk);
            #2;
            k++;
        end
    endtask

    task automatic waitIdle(input int budget);
        int k = 0;
        while (!(irq_tx_empty && !tx_busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] st;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkCnt++;
        if (tx_start !== 1'b0) $display("[TB] FAIL reset_tx_start: got %b want 0", tx_start); else passCnt++;
        checkCnt++;
        if (tx_data !== 8'h00) $display("[TB] FAIL reset_tx_data: got %h want 00", tx_data); else passCnt++;
        checkCnt++;
        if (irq_tx_empty !== 1'b1) $display("[TB] FAIL reset_irq: got %b want 1", irq_tx_empty); else passCnt++;
        checkCnt++;
        if (read_data !== 32'h0) $display("[TB] FAIL reset_read_data: got %h want 0", read_data); else passCnt++;
        @(negedge clk);
        rst_n = 1'b1;
        cpuRead(st);
        checkCnt++;
        if (st !== 32'h0000_0004) $display("[TB] FAIL reset_status: got %h want 00000004", st); else passCnt++;
    endtask

    task automatic test_idle_launch();
        logic [31:0] st;
        logic [7:0]  exp;
        int          c;
        busyLen = 6;
        pushByte(8'h41);
        c = lastPushCycle;
        waitObs(1, 40);
        waitCycles(10);
        checkCnt++;
        if (obsData.size() != 1) $display("[TB] FAIL idle_pulse_count: got %0d want 1", obsData.size()); else passCnt++;
        if (obsData.size() > 0) begin
            exp = expQ.pop_front();
            checkCnt++;
            if (obsData[0] !== exp) $display("[TB] FAIL idle_byte: got %h want %h", obsData[0], exp); else passCnt++;
            checkCnt++;
            if (obsCycle[0] != c + 2) $display("[TB] FAIL idle_latency: got cycle %0d want %0d", obsCycle[0], c + 2); else passCnt++;
        end
        waitIdle(100);
        cpuRead(st);
        checkCnt++;
        if (st !== 32'h0000_0004) $display("[TB] FAIL idle_status_after: got %h want 00000004", st); else passCnt++;
        expQ.delete();
        obsData.delete();
        obsCycle.delete();
    endtask

    task automatic test_back_to_back();
        logic [31:0] st;
        logic [7:0]  exp;
        logic        spaced;
        busyLen = 20;
        for (int i = 1; i <= 5; i++) pushByte(8'(i));
        waitObs(5, 400);
        checkCnt++;
        if (obsData.size() != 5) $display("[TB] FAIL burst_count: got %0d want 5", obsData.size()); else passCnt++;
        for (int i = 0; i < obsData.size() && expQ.size() > 0; i++) begin
            exp = expQ.pop_front();
            checkCnt++;
            if (obsData[i] !== exp) $display("[TB] FAIL burst_byte%0d: got %h want %h", i, obsData[i], exp); else passCnt++;
            if (i > 0) begin
                spaced = (obsCycle[i] - obsCycle[i-1]) >= busyLen + 2;
                checkCnt++;
                if (spaced !== 1'b1) $display("[TB] FAIL burst_spacing%0d: got %0d cycles want >= %0d", i, obsCycle[i] - obsCycle[i-1], busyLen + 2); else passCnt++;
            end
        end
        waitIdle(100);
        checkCnt++;
        if (irq_tx_empty !== 1'b1) $display("[TB] FAIL burst_irq: got %b want 1", irq_tx_empty); else passCnt++;
        cpuRead(st);
        checkCnt++;
        if (st !== 32'h0000_0004) $display("[TB] FAIL burst_status: got %h want 00000004", st); else passCnt++;
        expQ.delete();
        obsData.delete();
        obsCycle.delete();
    endtask

    task automatic test_overflow();
        logic [31:0] st;
        logic [7:0]  exp;
        busyLen = 3;
        holdBusy = 1'b1;
        for (int i = 0; i < DEPTH; i++) pushByte(8'h80 + 8'(i));
        applyStimulus(1'b0, 32'h0000_0090);
        cpuRead(st);
        checkCnt++;
        if (st !== 32'h0000_100B) $display("[TB] FAIL ovf_status: got %h want 0000100b", st); else passCnt++;
        applyStimulus(1'b1, 32'hFFFF_FFF7);
        cpuRead(st);
        checkCnt++;
        if (st !== 32'h0000_100B) $display("[TB] FAIL ovf_other_bits: got %h want 0000100b", st); else passCnt++;
        applyStimulus(1'b1, 32'h0000_0008);
        cpuRead(st);
        checkCnt++;
        if (st !== 32'h0000_1003) $display("[TB] FAIL ovf_clear: got %h want 00001003", st); else passCnt++;
        checkCnt++;
        if (obsData.size() != 0) $display("[TB] FAIL ovf_no_send_busy: got %0d want 0", obsData.size()); else passCnt++;
        holdBusy = 1'b0;
        waitObs(DEPTH, 400);
        waitIdle(100);
        waitCycles(10);
        checkCnt++;
        if (obsData.size() != DEPTH) $display("[TB] FAIL ovf_sent_count: got %0d want %0d", obsData.size(), DEPTH); else passCnt++;
        for (int i = 0; i < obsData.size() && expQ.size() > 0; i++) begin
            exp = expQ.pop_front();
            checkCnt++;
            if (obsData[i] !== exp) $display("[TB] FAIL ovf_byte%0d: got %h want %h", i, obsData[i], exp); else passCnt++;
        end
        cpuRead(st);
        checkCnt++;
        if (st !== 32'h0000_0004) $display("[TB] FAIL ovf_drained: got %h want 00000004", st); else passCnt++;
        expQ.delete();
        obsData.delete();
        obsCycle.delete();
    endtask

    task automatic test_simultaneous();
        logic [31:0] st;
        logic [7:0]  exp;
        busyLen = 3;
        holdBusy = 1'b1;
        for (int i = 0; i < DEPTH; i++) pushByte(8'hA0 + 8'(i));
        // release busy and push into the full FIFO on the same edge as the pop
        @(negedge clk);
        holdBusy = 1'b0;
        cs = 1'b1;
        write_enable = 1'b1;
        addr = 1'b0;
        write_data = 32'h0000_00EE;
        @(posedge clk);
        #1;
        cs = 1'b0;
        write_enable = 1'b0;
        write_data = '0;
        cpuRead(st);
        checkCnt++;
        if (st !== 32'h0000_0F09) $display("[TB] FAIL simul_status: got %h want 00000f09", st); else passCnt++;
        waitObs(DEPTH, 400);
        waitIdle(100);
        waitCycles(10);
        checkCnt++;
        if (obsData.size() != DEPTH) $display("[TB] FAIL simul_sent_count: got %0d want %0d", obsData.size(), DEPTH); else passCnt++;
        for (int i = 0; i < obsData.size() && expQ.size() > 0; i++) begin
            exp = expQ.pop_front();
            checkCnt++;
            if (obsData[i] !== exp) $display("[TB] FAIL simul_byte%0d: got %h want %h", i, obsData[i], exp); else passCnt++;
        end
        applyStimulus(1'b1, 32'h0000_0008);
        cpuRead(st);
        checkCnt++;
        if (st !== 32'h0000_0004) $display("[TB] FAIL simul_cleared: got %h want 00000004", st); else passCnt++;
        expQ.delete();
        obsData.delete();
        obsCycle.delete();
    endtask

    task automatic test_reset_midframe();
        logic [31:0] st;
        logic [7:0]  exp;
        busyLen = 30;
        for (int i = 1; i <= 4; i++) pushByte(8'hC0 + 8'(i));
        waitObs(1, 40);
        waitCycles(5);
        cpuRead(st);
        checkCnt++;
        if (st !== 32'h0000_0301) $display("[TB] FAIL mid_status_before: got %h want 00000301", st); else passCnt++;
        checkCnt++;
        if (obsData.size() != 1) $display("[TB] FAIL mid_first_count: got %0d want 1", obsData.size()); else passCnt++;
        if (obsData.size() > 0) begin
            exp = expQ.pop_front();
            checkCnt++;
            if (obsData[0] !== exp) $display("[TB] FAIL mid_first_byte: got %h want %h", obsData[0], exp); else passCnt++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkCnt++;
        if (tx_start !== 1'b0) $display("[TB] FAIL mid_tx_start: got %b want 0", tx_start); else passCnt++;
        checkCnt++;
        if (irq_tx_empty !== 1'b1) $display("[TB] FAIL mid_irq: got %b want 1", irq_tx_empty); else passCnt++;
        expQ.delete();
        obsData.delete();
        obsCycle.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cpuRead(st);
        checkCnt++;
        if (st !== 32'h0000_0004) $display("[TB] FAIL mid_status_after: got %h want 00000004", st); else passCnt++;
        waitCycles(60);
        checkCnt++;
        if (obsData.size() != 0) $display("[TB] FAIL mid_no_relaunch: got %0d pulses want 0", obsData.size()); else passCnt++;
    endtask

    task automatic test_wrap();
        logic [31:0] st;
        logic [7:0]  exp;
        logic        inRange;
        int          total;
        int          k;
        total = 3 * DEPTH;
        busyLen = 2;
        for (int i = 0; i < total; i++) begin
            waitCycles(int'($urandom_range(0, 3)));
            k = 0;
            cpuRead(st);
            while (st[1] && k < 200) begin
                cpuRead(st);
                k++;
            end
            inRange = (st[15:8] <= 8'd16);
            checkCnt++;
            if (inRange !== 1'b1) $display("[TB] FAIL wrap_count%0d: got %0d want <= 16", i, st[15:8]); else passCnt++;
            pushByte(8'($urandom));
        end
        waitObs(total, 2000);
        waitIdle(200);
        checkCnt++;
        if (obsData.size() != total) $display("[TB] FAIL wrap_sent_count: got %0d want %0d", obsData.size(), total); else passCnt++;
        for (int i = 0; i < obsData.size() && expQ.size() > 0; i++) begin
            exp = expQ.pop_front();
            checkCnt++;
            if (obsData[i] !== exp) $display("[TB] FAIL wrap_byte%0d: got %h want %h", i, obsData[i], exp); else passCnt++;
        end
        expQ.delete();
        obsData.delete();
        obsCycle.delete();
    endtask

    initial begin
        test_reset();
        test_idle_launch();
        test_back_to_back();
        test_overflow();
        test_simultaneous();
        test_reset_midframe();
        test_wrap();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
